// File: rtl/rca_cpu_reg_config_unit_if.sv
// Config-instruction handshake between the custom-instruction issue stage
// and the RCA register config unit. The issue stage is the master.
interface rca_cpu_reg_config_unit_if;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [2:0]  cfg_funct3;
  logic [6:0]  cfg_funct7;
  logic [31:0] cfg_rs1;
  logic [31:0] cfg_rs2;
  logic        cfg_done;
  logic        cfg_err;

  modport master (
    output cfg_valid,
    output cfg_funct3,
    output cfg_funct7,
    output cfg_rs1,
    output cfg_rs2,
    input  cfg_ready,
    input  cfg_done,
    input  cfg_err
  );

  modport slave (
    input  cfg_valid,
    input  cfg_funct3,
    input  cfg_funct7,
    input  cfg_rs1,
    input  cfg_rs2,
    output cfg_ready,
    output cfg_done,
    output cfg_err
  );
endinterface

// File: rtl/rca_cpu_reg_config_unit.sv
// RCA CPU register config unit.
// Executes the Register Config (funct3=001) and IO Input Use Config
// (funct3=101) custom instructions. Each RCA owns a table of CPU register
// addresses for its src ports and its feedback / non-feedback write ports,
// plus an IO input usage mask. A table update to a busy RCA is held in
// WAIT_IDLE until that RCA goes idle, so an executing RCA never sees its
// steering change underneath it. Register x0 in a table means unused/discard.
module rca_cpu_reg_config_unit #(
  parameter int NUM_RCAS        = 4,
  parameter int NUM_READ_PORTS  = 5,
  parameter int NUM_WRITE_PORTS = 5,
  parameter int REG_ADDR_W      = 5
) (
  input  logic                                              clk,
  input  logic                                              rst_n,
  rca_cpu_reg_config_unit_if.slave                          cfg,
  input  logic [NUM_RCAS-1:0]                               rca_busy,
  output logic [NUM_RCAS*NUM_READ_PORTS*REG_ADDR_W-1:0]     src_addr,
  output logic [NUM_RCAS*NUM_WRITE_PORTS*REG_ADDR_W-1:0]    dst_addr_fb,
  output logic [NUM_RCAS*NUM_WRITE_PORTS*REG_ADDR_W-1:0]    dst_addr_nfb,
  output logic [NUM_RCAS*NUM_READ_PORTS-1:0]                io_input_use
);

  localparam int RCA_W = (NUM_RCAS > 1) ? $clog2(NUM_RCAS) : 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_IDLE = 2'd1,
    COMMIT    = 2'd2
  } state_t;

  // Which table the latched instruction will update.
  typedef enum logic [1:0] {
    OP_SRC     = 2'd0,
    OP_DST_FB  = 2'd1,
    OP_DST_NFB = 2'd2,
    OP_IO      = 2'd3
  } op_t;

  typedef logic [REG_ADDR_W-1:0] addr_t;

  // Control state and handshake outputs
  state_t                    state_q, state_d;
  logic                      ready_q, ready_d;
  logic                      done_q, done_d;
  logic                      err_q, err_d;

  // Latched instruction fields
  logic [RCA_W-1:0]          rca_q, rca_d;
  op_t                       op_q, op_d;
  logic [2:0]                port_q, port_d;
  addr_t                     data_q, data_d;
  logic [NUM_READ_PORTS-1:0] mask_q, mask_d;
  logic                      bad_q, bad_d;

  // Per-RCA configuration tables
  addr_t                     src_q [NUM_RCAS][NUM_READ_PORTS];
  addr_t                     src_d [NUM_RCAS][NUM_READ_PORTS];
  addr_t                     fb_q  [NUM_RCAS][NUM_WRITE_PORTS];
  addr_t                     fb_d  [NUM_RCAS][NUM_WRITE_PORTS];
  addr_t                     nfb_q [NUM_RCAS][NUM_WRITE_PORTS];
  addr_t                     nfb_d [NUM_RCAS][NUM_WRITE_PORTS];
  logic [NUM_READ_PORTS-1:0] io_q  [NUM_RCAS];
  logic [NUM_READ_PORTS-1:0] io_d  [NUM_RCAS];

  // Decode of the instruction currently presented
  logic                      accept;
  logic                      rca_ok;
  logic                      is_reg;
  logic                      is_io;
  logic                      port_ok;
  logic                      instr_ok;
  logic                      target_busy;
  logic [RCA_W-1:0]          req_rca;
  op_t                       req_op;

  // High operand bits carry no meaning for these instructions.
  logic                      unused_rs_bits;

  assign unused_rs_bits = ^{cfg.cfg_rs1[31:5], cfg.cfg_rs2[31:REG_ADDR_W]};

  assign accept      = cfg.cfg_valid && ready_q;
  assign req_rca     = cfg.cfg_funct7[RCA_W-1:0];
  assign rca_ok      = 32'(cfg.cfg_funct7) < NUM_RCAS;
  assign is_reg      = cfg.cfg_funct3 == 3'b001;
  assign is_io       = cfg.cfg_funct3 == 3'b101;
  // rs1[3] selects a write (dst) port, otherwise a src port.
  assign port_ok     = cfg.cfg_rs1[3] ? (32'(cfg.cfg_rs1[2:0]) < NUM_WRITE_PORTS)
                                      : (32'(cfg.cfg_rs1[2:0]) < NUM_READ_PORTS);
  assign instr_ok    = rca_ok && (is_io || (is_reg && port_ok));
  assign target_busy = rca_busy[req_rca];
  assign req_op      = is_io           ? OP_IO :
                       !cfg.cfg_rs1[3] ? OP_SRC :
                       cfg.cfg_rs1[4]  ? OP_DST_FB : OP_DST_NFB;

  // Next-state logic: accept, wait for the target RCA to go idle, then commit.
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    rca_d   = rca_q;
    op_d    = op_q;
    port_d  = port_q;
    data_d  = data_q;
    mask_d  = mask_q;
    bad_d   = bad_q;
    src_d   = src_q;
    fb_d    = fb_q;
    nfb_d   = nfb_q;
    io_d    = io_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          rca_d  = req_rca;
          op_d   = req_op;
          port_d = cfg.cfg_rs1[2:0];
          data_d = cfg.cfg_rs2[REG_ADDR_W-1:0];
          mask_d = cfg.cfg_rs1[NUM_READ_PORTS-1:0];
          bad_d  = !instr_ok;
          // Rejected instructions never touch a table, so they skip the wait.
          if (instr_ok && target_busy) begin
            state_d = WAIT_IDLE;
          end else begin
            state_d = COMMIT;
            done_d  = instr_ok;
            err_d   = !instr_ok;
          end
        end
      end

      WAIT_IDLE: begin
        if (!rca_busy[rca_q]) begin
          state_d = COMMIT;
          done_d  = 1'b1;
        end
      end

      COMMIT: begin
        state_d = IDLE;
        if (!bad_q) begin
          for (int r = 0; r < NUM_RCAS; r++) begin
            if (rca_q == RCA_W'(r)) begin
              for (int p = 0; p < NUM_READ_PORTS; p++) begin
                if (op_q == OP_SRC && port_q == 3'(p)) begin
                  src_d[r][p] = data_q;
                end
              end
              for (int p = 0; p < NUM_WRITE_PORTS; p++) begin
                if (op_q == OP_DST_FB && port_q == 3'(p)) begin
                  fb_d[r][p] = data_q;
                end
                if (op_q == OP_DST_NFB && port_q == 3'(p)) begin
                  nfb_d[r][p] = data_q;
                end
              end
              if (op_q == OP_IO) begin
                io_d[r] = mask_q;
              end
            end
          end
        end
      end

      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE);
  end

  // State, handshake outputs and tables; everything clears on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rca_q   <= '0;
      op_q    <= OP_SRC;
      port_q  <= '0;
      data_q  <= '0;
      mask_q  <= '0;
      bad_q   <= 1'b0;
      src_q   <= '{default: '0};
      fb_q    <= '{default: '0};
      nfb_q   <= '{default: '0};
      io_q    <= '{default: '0};
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rca_q   <= rca_d;
      op_q    <= op_d;
      port_q  <= port_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
      bad_q   <= bad_d;
      src_q   <= src_d;
      fb_q    <= fb_d;
      nfb_q   <= nfb_d;
      io_q    <= io_d;
    end
  end

  assign cfg.cfg_ready = ready_q;
  assign cfg.cfg_done  = done_q;
  assign cfg.cfg_err   = err_q;

  // Flatten the tables onto the output buses, RCA-major.
  for (genvar r = 0; r < NUM_RCAS; r++) begin : g_rca
    for (genvar p = 0; p < NUM_READ_PORTS; p++) begin : g_src
      assign src_addr[(r*NUM_READ_PORTS+p)*REG_ADDR_W +: REG_ADDR_W] = src_q[r][p];
    end
    for (genvar p = 0; p < NUM_WRITE_PORTS; p++) begin : g_dst
      assign dst_addr_fb[(r*NUM_WRITE_PORTS+p)*REG_ADDR_W +: REG_ADDR_W]  = fb_q[r][p];
      assign dst_addr_nfb[(r*NUM_WRITE_PORTS+p)*REG_ADDR_W +: REG_ADDR_W] = nfb_q[r][p];
    end
    assign io_input_use[r*NUM_READ_PORTS +: NUM_READ_PORTS] = io_q[r];
  end

endmodule
